// File: rtl/range_walker.sv
// range_walker: emits every index from left to right bound, one per accepted valid/ready beat
module range_walker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             abort,
  output logic [WIDTH-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             first,
  output logic             last,
  output logic             descending,
  output logic [WIDTH:0]   length,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] lreg, rreg;
  logic [WIDTH:0] span;
  logic launch, step;
  always_comb begin
    launch = state == IDLE && start && !abort;
    step = state == RUN && idx_ready && !abort && idx != rreg;
    state_nx = abort ? IDLE
             : state == IDLE ? (start ? RUN : IDLE)
             : state == RUN ? (idx_ready && idx == rreg ? DONE : RUN)
             : IDLE;
    span = (left > right ? {1'b0, left} - {1'b0, right} : {1'b0, right} - {1'b0, left}) + (WIDTH+1)'(1);
    idx_valid = state == RUN;
    busy = state != IDLE;
    done = state == DONE;
    first = idx_valid && idx == lreg;
    last = idx_valid && idx == rreg;
  end
  // The end of a walk is found by matching rreg, so idx never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      lreg <= '0;
      rreg <= '0;
      descending <= 1'b0;
      length <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        idx <= left;
        lreg <= left;
        rreg <= right;
        descending <= left > right;
        length <= span;
      end else if (step) begin
        idx <= descending ? idx - WIDTH'(1) : idx + WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_range_walker.sv
// tb_range_walker: directed scenario tasks for range_walker with inline checks
module tb_range_walker;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, idx_ready = 0;
  logic [7:0] left = 0, right = 0, idx;
  logic idx_valid, first, last, descending, busy, done;
  logic [8:0] length;
  int pass_cnt = 0, total = 0;

  range_walker #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .left(left), .right(right),
    .abort(abort), .idx(idx), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .first(first), .last(last), .descending(descending), .length(length),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    step;
    total++;
    if ({idx, idx_valid, first, last, descending, length, busy, done} !== 23'd0)
      $display("FAIL reset_state got=%h want=0", {idx, idx_valid, first, last, descending, length, busy, done});
    else pass_cnt++;
    rst_n = 1;
    step;
  endtask

  task automatic run_walk(input logic [7:0] l, input logic [7:0] r, input logic ed, input logic [8:0] el);
    int e;
    idx_ready = 1; left = l; right = r; start = 1;
    step;
    start = 0; left = ~l; right = ~r;
    e = l;
    for (int i = 0; i < el; i++) begin
      total++;
      if ({idx_valid, idx, first, last, descending, length, busy, done} !== {1'b1, e[7:0], i == 0, i == el - 1, ed, el, 1'b1, 1'b0})
        $display("FAIL walk_beat l=%0d r=%0d i=%0d got v=%b idx=%0d f=%b l=%b d=%b len=%0d want idx=%0d d=%b len=%0d",
                 l, r, i, idx_valid, idx, first, last, descending, length, e, ed, el);
      else pass_cnt++;
      e = ed ? e - 1 : e + 1;
      step;
    end
    total++;
    if ({done, idx_valid, busy, idx, first, last} !== {1'b1, 1'b0, 1'b1, r, 1'b0, 1'b0})
      $display("FAIL walk_done l=%0d r=%0d got done=%b v=%b busy=%b idx=%0d want done=1 v=0 busy=1 idx=%0d", l, r, done, idx_valid, busy, idx, r);
    else pass_cnt++;
    step;
    total++;
    if ({done, busy, idx, descending, length} !== {1'b0, 1'b0, r, ed, el})
      $display("FAIL walk_idle l=%0d r=%0d got done=%b busy=%b idx=%0d d=%b len=%0d", l, r, done, busy, idx, descending, length);
    else pass_cnt++;
  endtask

  task automatic test_descending; run_walk(8'd2, 8'd0, 1'b1, 9'd3); endtask
  task automatic test_ascending;  run_walk(8'd0, 8'd2, 1'b0, 9'd3); endtask
  task automatic test_single;     run_walk(8'd5, 8'd5, 1'b0, 9'd1); endtask
  task automatic test_full_range;
    run_walk(8'd255, 8'd0, 1'b1, 9'd256);
    step;
    run_walk(8'd0, 8'd255, 1'b0, 9'd256);
  endtask

  task automatic test_ready_toggle;
    int exp_i;
    logic [7:0] held;
    bit hold, seen_done;
    idx_ready = 0; left = 3; right = 7; start = 1;
    step;
    start = 0; left = 100; right = 101;
    exp_i = 3; hold = 0; seen_done = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (hold) begin
        total++;
        if (idx !== held) $display("FAIL toggle_stable got=%0d want=%0d", idx, held);
        else pass_cnt++;
      end
      if (done) seen_done = 1;
      else begin
        idx_ready = (c % 4 == 0) || (c % 4 == 3);
        start = (c == 2);
        if (idx_valid && idx_ready) begin
          total++;
          if (idx !== 8'(exp_i)) $display("FAIL toggle_beat got=%0d want=%0d", idx, exp_i);
          else pass_cnt++;
          exp_i++;
          hold = 0;
        end else begin
          hold = idx_valid;
          held = idx;
        end
        step;
        start = 0;
      end
    end
    total++;
    if (!seen_done || exp_i != 8) $display("FAIL toggle_end got done_seen=%0d next=%0d want 1 and 8", seen_done, exp_i);
    else pass_cnt++;
    idx_ready = 1;
    step;
  endtask

  task automatic test_abort;
    bit found = 0;
    idx_ready = 1; left = 9; right = 0; start = 1;
    step;
    start = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (idx_valid && idx == 4) found = 1;
      else step;
    end
    total++;
    if (!found) $display("FAIL abort_reach got idx=%0d want 4", idx);
    else pass_cnt++;
    abort = 1; start = 1;
    step;
    abort = 0; start = 0;
    total++;
    if ({idx_valid, busy, done, idx} !== {3'b000, 8'd4})
      $display("FAIL abort_next got v=%b busy=%b done=%b idx=%0d want 0 0 0 4", idx_valid, busy, done, idx);
    else pass_cnt++;
    step;
    total++;
    if ({idx_valid, busy, done} !== 3'b000) $display("FAIL abort_nodone got v=%b busy=%b done=%b want 000", idx_valid, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    idx_ready = 1; left = 10; right = 20; start = 1;
    step;
    start = 0;
    step; step;
    rst_n = 0;
    step;
    total++;
    if ({idx, idx_valid, first, last, descending, length, busy, done} !== 23'd0)
      $display("FAIL reset_mid got=%h want=0", {idx, idx_valid, first, last, descending, length, busy, done});
    else pass_cnt++;
    rst_n = 1;
    step;
    run_walk(8'd1, 8'd3, 1'b0, 9'd3);
  endtask

  task automatic test_back_to_back;
    idx_ready = 1; left = 5; right = 6; start = 1;
    step;
    start = 0;
    step; step;
    total++;
    if (done !== 1'b1) $display("FAIL b2b_done got=%b want=1", done);
    else pass_cnt++;
    start = 1;
    step;
    total++;
    if ({busy, idx_valid} !== 2'b00) $display("FAIL b2b_start_in_done got busy=%b v=%b want 00", busy, idx_valid);
    else pass_cnt++;
    step;
    start = 0;
    total++;
    if ({idx_valid, idx, first} !== {1'b1, 8'd5, 1'b1}) $display("FAIL b2b_restart got v=%b idx=%0d f=%b want 1 5 1", idx_valid, idx, first);
    else pass_cnt++;
    abort = 1;
    step;
    abort = 0;
    step;
  endtask

  initial begin
    test_reset;
    test_descending;
    test_ascending;
    test_single;
    test_ready_toggle;
    test_full_range;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
